base_ram_arbiter: RTL and testbench
===================================

Name: base_ram_arbiter

Overview:
Arbitrates the single base SRAM between instruction fetch (IF) and data access (MEM). On a MEM access that hits the base RAM window it raises STALL_REQ_STR, which stall_ctrl turns into an IF/IC/ID freeze (`STALL_ID`). It then sequences the data read or write, and releases the stall with a one-cycle completion pulse. In all other cycles the SRAM serves fetch combinationally.

Parameters:
WAIT_CYCLES, 1, number of cycles the SRAM strobe (OE_N or WE_N) is held low for a data access; must be >= 1.
BASE_TAG, 10'h200, value of address bits [31:22] that selects base RAM (0x8000_0000–0x803F_FFFF).

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  synchronous, active-high reset (`RST_EN` = 1).
IF_ADDR  input  32  fetch address.
IF_RDATA  output  32  fetch data; equals BASE_DQ_I while the block is in IDLE or DONE, else 0.
MEM_REQ  input  1  MEM stage has a load or store this cycle.
MEM_WE  input  1  1 = store, 0 = load.
MEM_BE  input  4  byte enables, active high.
MEM_ADDR  input  32  data address.
MEM_WDATA  input  32  store data.
MEM_RDATA  output  32  registered load data; valid in DONE.
MEM_DONE  output  1  one-cycle pulse in DONE.
STALL_REQ_STR  output  1  `STOP`(1) or `NO_STOP`(0); feeds stall_ctrl.
BASE_ADDR  output  20  SRAM word address.
BASE_DQ_O  output  32  SRAM write data.
BASE_DQ_OE  output  1  tristate enable for BASE_DQ_O.
BASE_DQ_I  input  32  SRAM read data.
BASE_CE_N, BASE_OE_N, BASE_WE_N  output  1 each  SRAM strobes, active low.
BASE_BE_N  output  4  SRAM byte enables, active low.

Behaviour:
- hit = MEM_REQ && MEM_ADDR[31:22] == BASE_TAG. A MEM request that does not hit is ignored, because ext RAM and UART are handled elsewhere.
- States:
  - IDLE
    - Fetch path: BASE_ADDR = IF_ADDR[21:2], CE_N = 0, OE_N = 0, WE_N = 1, BE_N = 0, DQ_OE = 0.
    - On hit: STALL_REQ_STR = `STOP` combinationally in the same cycle, because stall_ctrl is combinational and IF must hold this cycle.
    - At the edge on a hit: latch addr, wdata, be and we; clear the counter; go to D_RD (load) or D_WR (store).
  - D_RD
    - BASE_ADDR = latched[21:2], OE_N = 0, BE_N = 0, STALL = `STOP`.
    - The counter increments each cycle.
    - At count == WAIT_CYCLES-1: register BASE_DQ_I into MEM_RDATA, go to DONE.
  - D_WR
    - Latched address; DQ_OE = 1; DQ_O = latched wdata; WE_N = 0; OE_N = 1; BE_N = ~latched be; STALL = `STOP`.
    - After WAIT_CYCLES cycles go to D_WHOLD.
  - D_WHOLD
    - WE_N = 1; address, data and DQ_OE are still driven (hold time); STALL = `STOP`.
    - Next state: DONE.
  - DONE
    - STALL = `NO_STOP`; MEM_DONE = 1; MEM_RDATA is held.
    - Fetch path is driven as in IDLE, since IF advances this cycle.
    - MEM_REQ is ignored, because it is the same instruction finishing.
    - Next state: IDLE.
- Load latency: 1 + WAIT_CYCLES + 1 cycles from the hit to the end of DONE.
- Store latency: 1 + WAIT_CYCLES + 2 cycles from the hit to the end of DONE.
- Zero-byte store (be = 0): still runs the full sequence with BE_N = 4'hF; no special case.
- STALL_REQ_STR is never asserted in DONE. Back-to-back hits therefore produce one free-running cycle (DONE) between stalls.
- Reset values: state IDLE, counter 0, MEM_RDATA 0, MEM_DONE 0, STALL_REQ_STR `NO_STOP`, latched registers 0. Strobe outputs follow IDLE decode.
- Reset mid-access:
  - The state returns to IDLE at that edge; WE_N goes high and DQ_OE drops in the following cycle.
  - No MEM_DONE is generated, and the stall is released.
  - A partially written SRAM word is undefined.

Decomposition:
- defines.vh: add `BASE_TAG_DEFAULT`, the base-RAM state encoding, and `SRAM_ADDR_BUS` [19:0].
- Reuse `STOP`, `NO_STOP`, `RST_EN`.
- Sub-module: sram_wait_counter (WAIT_CYCLES-bit counter with clear and terminal-count flag) is natural. Counter width is $clog2(WAIT_CYCLES+1).
- Everything else stays flat.

Test Plan:
1. No MEM_REQ, IF_ADDR = 0x8000_0010, BASE_DQ_I = 0x2402_0001 → BASE_ADDR = 0x00004, IF_RDATA = 0x2402_0001, STALL_REQ_STR = 0, state stays IDLE.
2. WAIT_CYCLES = 2, load hit at 0x8000_0100, DQ_I = 0xDEAD_BEEF → STALL high for exactly 3 cycles, BASE_ADDR = 0x00040, OE_N low. Next cycle: MEM_DONE = 1, MEM_RDATA = 0xDEAD_BEEF, STALL = 0.
3. Store hit at 0x8000_0204, be = 4'b0011, wdata = 0x1234_5678 → WE_N low for 2 cycles with BE_N = 4'b1100 and DQ_OE = 1, then a 1-cycle hold with WE_N high and DQ_OE still 1, then DONE. STALL high for 4 cycles.
4. MEM_REQ at 0x8040_0000 (ext window) or 0xBFD0_03F8 → STALL never asserted, fetch undisturbed, MEM_DONE never pulses.
5. MEM_REQ held high through DONE and again at the following IDLE → exactly two access sequences, separated by one DONE cycle with STALL = 0.
6. RST = 1 during the second cycle of D_WR → next cycle: IDLE, WE_N = 1, DQ_OE = 0, STALL = 0, and no MEM_DONE pulse.

Source files
------------

// File: rtl/base_ram_arbiter_pkg.sv
// Shared constants and state encoding for the base SRAM arbiter.
package base_ram_arbiter_pkg;

    localparam logic       STOP             = 1'b1;
    localparam logic       NO_STOP          = 1'b0;
    localparam logic       RST_EN           = 1'b1;
    localparam logic [9:0] BASE_TAG_DEFAULT = 10'h200;
    localparam int         SRAM_ADDR_W      = 20;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_D_RD    = 3'd1,
        ST_D_WR    = 3'd2,
        ST_D_WHOLD = 3'd3,
        ST_DONE    = 3'd4
    } base_state_t;

endpackage

// File: rtl/base_ram_arbiter_sram_wait_counter.sv
// Strobe-width counter: cleared while idle, counts during a data access and
// flags the last strobe cycle.
module base_ram_arbiter_sram_wait_counter
    import base_ram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = $clog2(WAIT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST == RST_EN || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/base_ram_arbiter.sv
// Shares the base SRAM between instruction fetch and MEM-stage data accesses;
// fetch is served combinationally whenever no data access is in flight.
module base_ram_arbiter
    import base_ram_arbiter_pkg::*;
#(
    parameter int         WAIT_CYCLES = 1,
    parameter logic [9:0] BASE_TAG    = BASE_TAG_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IF_ADDR,
    output logic [31:0] IF_RDATA,
    input  logic        MEM_REQ,
    input  logic        MEM_WE,
    input  logic [3:0]  MEM_BE,
    input  logic [31:0] MEM_ADDR,
    input  logic [31:0] MEM_WDATA,
    output logic [31:0] MEM_RDATA,
    output logic        MEM_DONE,
    output logic        STALL_REQ_STR,
    output logic [19:0] BASE_ADDR,
    output logic [31:0] BASE_DQ_O,
    output logic        BASE_DQ_OE,
    input  logic [31:0] BASE_DQ_I,
    output logic        BASE_CE_N,
    output logic        BASE_OE_N,
    output logic        BASE_WE_N,
    output logic [3:0]  BASE_BE_N
);

    base_state_t state;
    sram_addr_t  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        hit;
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_tc;
    logic        unused_addr_bits;

    assign hit              = MEM_REQ && (MEM_ADDR[31:22] == BASE_TAG);
    assign unused_addr_bits = ^{IF_ADDR[31:22], IF_ADDR[1:0], MEM_ADDR[1:0]};

    assign cnt_clr = (state == ST_IDLE);
    assign cnt_en  = (state == ST_D_RD) || (state == ST_D_WR);

    base_ram_arbiter_sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .CLK (CLK),
        .RST (RST),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    // A request arriving in DONE belongs to the instruction just finishing,
    // so only IDLE may start a new access.
    always_ff @(posedge CLK) begin
        if (RST == RST_EN) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            MEM_RDATA <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        addr_q  <= MEM_ADDR[21:2];
                        wdata_q <= MEM_WDATA;
                        be_q    <= MEM_BE;
                        state   <= MEM_WE ? ST_D_WR : ST_D_RD;
                    end
                end
                ST_D_RD: begin
                    if (cnt_tc) begin
                        MEM_RDATA <= BASE_DQ_I;
                        state     <= ST_DONE;
                    end
                end
                ST_D_WR: begin
                    if (cnt_tc) begin
                        state <= ST_D_WHOLD;
                    end
                end
                ST_D_WHOLD: state <= ST_DONE;
                ST_DONE:    state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // SRAM pin decode; the stall must be combinational in IDLE because the
    // stall controller is combinational and IF has to hold this very cycle.
    always_comb begin
        BASE_ADDR     = IF_ADDR[21:2];
        BASE_DQ_O     = wdata_q;
        BASE_DQ_OE    = 1'b0;
        BASE_CE_N     = 1'b0;
        BASE_OE_N     = 1'b0;
        BASE_WE_N     = 1'b1;
        BASE_BE_N     = 4'h0;
        STALL_REQ_STR = NO_STOP;
        MEM_DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                STALL_REQ_STR = hit ? STOP : NO_STOP;
            end
            ST_D_RD: begin
                BASE_ADDR     = addr_q;
                STALL_REQ_STR = STOP;
            end
            ST_D_WR: begin
                BASE_ADDR     = addr_q;
                BASE_DQ_OE    = 1'b1;
                BASE_OE_N     = 1'b1;
                BASE_WE_N     = 1'b0;
                BASE_BE_N     = ~be_q;
                STALL_REQ_STR = STOP;
            end
            ST_D_WHOLD: begin
                BASE_ADDR     = addr_q;
                BASE_DQ_OE    = 1'b1;
                BASE_OE_N     = 1'b1;
                BASE_BE_N     = ~be_q;
                STALL_REQ_STR = STOP;
            end
            ST_DONE: begin
                MEM_DONE = 1'b1;
            end
            default: begin
                STALL_REQ_STR = NO_STOP;
            end
        endcase
    end

    assign IF_RDATA = (state == ST_IDLE || state == ST_DONE) ? BASE_DQ_I : 32'h0;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: directed vectors, hand-written access sequences
// and a randomized run against a cycle-schedule reference model.
module tb_base_ram_arbiter;

    localparam int W = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IF_ADDR;
    logic [31:0] IF_RDATA;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;
    logic        MEM_DONE;
    logic        STALL_REQ_STR;
    logic [19:0] BASE_ADDR;
    logic [31:0] BASE_DQ_O;
    logic        BASE_DQ_OE;
    logic [31:0] BASE_DQ_I;
    logic        BASE_CE_N;
    logic        BASE_OE_N;
    logic        BASE_WE_N;
    logic [3:0]  BASE_BE_N;

    base_ram_arbiter #(
        .WAIT_CYCLES (W),
        .BASE_TAG    (10'h200)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .IF_ADDR       (IF_ADDR),
        .IF_RDATA      (IF_RDATA),
        .MEM_REQ       (MEM_REQ),
        .MEM_WE        (MEM_WE),
        .MEM_BE        (MEM_BE),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_WDATA     (MEM_WDATA),
        .MEM_RDATA     (MEM_RDATA),
        .MEM_DONE      (MEM_DONE),
        .STALL_REQ_STR (STALL_REQ_STR),
        .BASE_ADDR     (BASE_ADDR),
        .BASE_DQ_O     (BASE_DQ_O),
        .BASE_DQ_OE    (BASE_DQ_OE),
        .BASE_DQ_I     (BASE_DQ_I),
        .BASE_CE_N     (BASE_CE_N),
        .BASE_OE_N     (BASE_OE_N),
        .BASE_WE_N     (BASE_WE_N),
        .BASE_BE_N     (BASE_BE_N)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] if_addr;
        logic        mem_req;
        logic [31:0] mem_addr;
        logic [31:0] dq_i;
        logic [19:0] exp_addr;
        logic [31:0] exp_if_rdata;
        logic        exp_stall;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        done;
        logic        we_n;
        logic        oe_n;
        logic        dq_oe;
        logic        fetch;
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        logic        capture;
    } exp_t;

    vec_t        vt[6];
    exp_t        sched[$];
    exp_t        e;
    logic [31:0] exp_rdata;
    logic [9:0]  st_pat;
    logic [9:0]  dn_pat;
    logic        m_hit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        MEM_REQ   = 1'b0;
        MEM_WE    = 1'b0;
        MEM_BE    = 4'h0;
        MEM_ADDR  = 32'h0;
        MEM_WDATA = 32'h0;
    endtask

    task automatic expect_cycle(input string tag, input logic stall, input logic done,
                                input logic we_n, input logic oe_n, input logic dq_oe,
                                input logic [19:0] addr, input logic [3:0] be_n);
        @(negedge CLK);
        check({tag, "_stall"}, 32'(STALL_REQ_STR), 32'(stall));
        check({tag, "_done"},  32'(MEM_DONE),      32'(done));
        check({tag, "_ce_n"},  32'(BASE_CE_N),     32'h0);
        check({tag, "_we_n"},  32'(BASE_WE_N),     32'(we_n));
        check({tag, "_oe_n"},  32'(BASE_OE_N),     32'(oe_n));
        check({tag, "_dq_oe"}, 32'(BASE_DQ_OE),    32'(dq_oe));
        check({tag, "_addr"},  32'(BASE_ADDR),     32'(addr));
        check({tag, "_be_n"},  32'(BASE_BE_N),     32'(be_n));
    endtask

    function automatic exp_t mk(input logic stall, input logic done, input logic we_n,
                                input logic oe_n, input logic dq_oe, input logic fetch,
                                input logic [19:0] addr, input logic [3:0] be_n,
                                input logic [31:0] wdata, input logic capture);
        exp_t r;
        r.stall   = stall;
        r.done    = done;
        r.we_n    = we_n;
        r.oe_n    = oe_n;
        r.dq_oe   = dq_oe;
        r.fetch   = fetch;
        r.addr    = addr;
        r.be_n    = be_n;
        r.wdata   = wdata;
        r.capture = capture;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        IF_ADDR   = 32'h8000_0000;
        BASE_DQ_I = 32'h0;
        idle_inputs();
        repeat (3) tick();
        RST = 1'b0;

        // reset state
        @(negedge CLK);
        check("rst_rdata", MEM_RDATA, 32'h0);
        check("rst_done",  32'(MEM_DONE),      32'h0);
        check("rst_stall", 32'(STALL_REQ_STR), 32'h0);
        check("rst_we_n",  32'(BASE_WE_N),     32'h1);
        check("rst_dq_oe", 32'(BASE_DQ_OE),    32'h0);
        tick();

        // table: fetch path with no base-window request
        vt[0] = '{32'h8000_0010, 1'b0, 32'h0000_0000, 32'h2402_0001, 20'h00004, 32'h2402_0001, 1'b0};
        vt[1] = '{32'h8000_0010, 1'b1, 32'h8040_0000, 32'h1111_2222, 20'h00004, 32'h1111_2222, 1'b0};
        vt[2] = '{32'h8000_3FFC, 1'b1, 32'hBFD0_03F8, 32'hA5A5_5A5A, 20'h00FFF, 32'hA5A5_5A5A, 1'b0};
        vt[3] = '{32'h803F_FFFC, 1'b1, 32'h7FFF_FFFC, 32'h0000_0000, 20'hFFFFF, 32'h0000_0000, 1'b0};
        vt[4] = '{32'h8012_3458, 1'b1, 32'h0040_0000, 32'hCAFE_BABE, 20'h48D16, 32'hCAFE_BABE, 1'b0};
        vt[5] = '{32'h0000_0000, 1'b1, 32'hC000_0000, 32'h0BAD_F00D, 20'h00000, 32'h0BAD_F00D, 1'b0};
        for (int i = 0; i < 6; i++) begin
            IF_ADDR   = vt[i].if_addr;
            MEM_REQ   = vt[i].mem_req;
            MEM_WE    = 1'b1;
            MEM_BE    = 4'hF;
            MEM_ADDR  = vt[i].mem_addr;
            BASE_DQ_I = vt[i].dq_i;
            @(negedge CLK);
            check($sformatf("vec%0d_addr", i),  32'(BASE_ADDR),     32'(vt[i].exp_addr));
            check($sformatf("vec%0d_ifrd", i),  IF_RDATA,           vt[i].exp_if_rdata);
            check($sformatf("vec%0d_stall", i), 32'(STALL_REQ_STR), 32'(vt[i].exp_stall));
            check($sformatf("vec%0d_we_n", i),  32'(BASE_WE_N),     32'h1);
            check($sformatf("vec%0d_done", i),  32'(MEM_DONE),      32'h0);
            tick();
        end
        idle_inputs();

        // load hit
        IF_ADDR   = 32'h8000_0040;
        BASE_DQ_I = 32'hDEAD_BEEF;
        MEM_REQ   = 1'b1;
        MEM_WE    = 1'b0;
        MEM_BE    = 4'hF;
        MEM_ADDR  = 32'h8000_0100;
        expect_cycle("ld0", 1, 0, 1, 0, 0, 20'h00010, 4'h0);
        tick();
        idle_inputs();
        expect_cycle("ld1", 1, 0, 1, 0, 0, 20'h00040, 4'h0);
        check("ld1_ifrd", IF_RDATA, 32'h0);
        tick();
        expect_cycle("ld2", 1, 0, 1, 0, 0, 20'h00040, 4'h0);
        tick();
        expect_cycle("ld3", 0, 1, 1, 0, 0, 20'h00010, 4'h0);
        check("ld3_rdata", MEM_RDATA, 32'hDEAD_BEEF);
        check("ld3_ifrd",  IF_RDATA,  32'hDEAD_BEEF);
        tick();
        BASE_DQ_I = 32'h0;
        expect_cycle("ld4", 0, 0, 1, 0, 0, 20'h00010, 4'h0);
        check("ld4_rdata_hold", MEM_RDATA, 32'hDEAD_BEEF);
        tick();

        // store hit
        MEM_REQ   = 1'b1;
        MEM_WE    = 1'b1;
        MEM_BE    = 4'b0011;
        MEM_ADDR  = 32'h8000_0204;
        MEM_WDATA = 32'h1234_5678;
        expect_cycle("st0", 1, 0, 1, 0, 0, 20'h00010, 4'h0);
        tick();
        idle_inputs();
        expect_cycle("st1", 1, 0, 0, 1, 1, 20'h00081, 4'b1100);
        check("st1_dq_o", BASE_DQ_O, 32'h1234_5678);
        tick();
        expect_cycle("st2", 1, 0, 0, 1, 1, 20'h00081, 4'b1100);
        check("st2_dq_o", BASE_DQ_O, 32'h1234_5678);
        tick();
        expect_cycle("st3", 1, 0, 1, 1, 1, 20'h00081, 4'b1100);
        check("st3_dq_o", BASE_DQ_O, 32'h1234_5678);
        tick();
        expect_cycle("st4", 0, 1, 1, 0, 0, 20'h00010, 4'h0);
        check("st4_rdata_hold", MEM_RDATA, 32'hDEAD_BEEF);
        tick();

        // back-to-back loads with MEM_REQ held through DONE
        MEM_REQ  = 1'b1;
        MEM_WE   = 1'b0;
        MEM_BE   = 4'hF;
        MEM_ADDR = 32'h8000_0300;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            st_pat[i] = STALL_REQ_STR;
            dn_pat[i] = MEM_DONE;
            tick();
            if (i == 4) idle_inputs();
        end
        check("b2b_stall_pattern", 32'(st_pat), 32'(10'b0001110111));
        check("b2b_done_pattern",  32'(dn_pat), 32'(10'b0010001000));

        // reset during the second D_WR cycle
        MEM_REQ   = 1'b1;
        MEM_WE    = 1'b1;
        MEM_BE    = 4'hF;
        MEM_ADDR  = 32'h8000_0208;
        MEM_WDATA = 32'h55AA_55AA;
        tick();
        idle_inputs();
        expect_cycle("rw1", 1, 0, 0, 1, 1, 20'h00082, 4'h0);
        tick();
        RST = 1'b1;
        expect_cycle("rw2", 1, 0, 0, 1, 1, 20'h00082, 4'h0);
        tick();
        RST = 1'b0;
        expect_cycle("rw3", 0, 0, 1, 0, 0, 20'h00010, 4'h0);
        check("rw3_rdata", MEM_RDATA, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check($sformatf("rw_after%0d_done", i),  32'(MEM_DONE),      32'h0);
            check($sformatf("rw_after%0d_stall", i), 32'(STALL_REQ_STR), 32'h0);
            tick();
        end

        // randomized run against the cycle-schedule model
        exp_rdata = 32'h0;
        for (int c = 0; c < 400; c++) begin
            IF_ADDR   = $urandom;
            BASE_DQ_I = $urandom;
            MEM_REQ   = ($urandom_range(0, 3) != 0);
            MEM_WE    = 1'($urandom_range(0, 1));
            MEM_BE    = 4'($urandom);
            MEM_WDATA = $urandom;
            case ($urandom_range(0, 2))
                0:       MEM_ADDR = 32'h8000_0000 + ($urandom & 32'h003F_FFFF);
                1:       MEM_ADDR = 32'h8040_0000 + ($urandom & 32'h003F_FFFF);
                default: MEM_ADDR = $urandom;
            endcase
            @(negedge CLK);
            m_hit = MEM_REQ && (MEM_ADDR >= 32'h8000_0000) && (MEM_ADDR <= 32'h803F_FFFF);
            if (sched.size() == 0) begin
                e = mk(m_hit, 0, 1, 0, 0, 1, 20'h0, 4'h0, 32'h0, 0);
                if (m_hit) begin
                    if (MEM_WE) begin
                        for (int k = 0; k < W; k++)
                            sched.push_back(mk(1, 0, 0, 1, 1, 0, MEM_ADDR[21:2], ~MEM_BE, MEM_WDATA, 0));
                        sched.push_back(mk(1, 0, 1, 1, 1, 0, MEM_ADDR[21:2], ~MEM_BE, MEM_WDATA, 0));
                    end else begin
                        for (int k = 0; k < W; k++)
                            sched.push_back(mk(1, 0, 1, 0, 0, 0, MEM_ADDR[21:2], 4'h0, 32'h0, (k == W - 1)));
                    end
                    sched.push_back(mk(0, 1, 1, 0, 0, 1, 20'h0, 4'h0, 32'h0, 0));
                end
            end else begin
                e = sched.pop_front();
            end
            check("rnd_stall", 32'(STALL_REQ_STR), 32'(e.stall));
            check("rnd_done",  32'(MEM_DONE),      32'(e.done));
            check("rnd_ce_n",  32'(BASE_CE_N),     32'h0);
            check("rnd_we_n",  32'(BASE_WE_N),     32'(e.we_n));
            check("rnd_oe_n",  32'(BASE_OE_N),     32'(e.oe_n));
            check("rnd_dq_oe", 32'(BASE_DQ_OE),    32'(e.dq_oe));
            check("rnd_be_n",  32'(BASE_BE_N),     32'(e.be_n));
            check("rnd_addr",  32'(BASE_ADDR),     32'(e.fetch ? IF_ADDR[21:2] : e.addr));
            check("rnd_ifrd",  IF_RDATA,           e.fetch ? BASE_DQ_I : 32'h0);
            check("rnd_rdata", MEM_RDATA,          exp_rdata);
            if (e.dq_oe) check("rnd_dq_o", BASE_DQ_O, e.wdata);
            if (e.capture) exp_rdata = BASE_DQ_I;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
